battle_engine_param: RTL and testbench
======================================

BATTLE_ENGINE_PARAM -- requirements
Module: battle_engine_param

Interface
REQ-001 SHALL have parameter HP_W, default 8, width of both HP counters.
REQ-002 SHALL have parameter HP_INIT, default 100, starting HP for both sides.
REQ-003 SHALL have parameter AMMO_W, default 5, width of the weapon-ammo counters.
REQ-004 SHALL have parameter BAT_INIT, default 4, starting baseball-bat uses per side.
REQ-005 SHALL have parameter SWORD_INIT, default 3, starting sword uses per side.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero damage-randomiser seed.
REQ-007 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- collision_detected  in  1  battle enable.
- act_valid  in  1  an action is offered.
- act_who  in  1  offering side: 0 player, 1 enemy.
- act_choice  in  2  00 punch, 01 kick, 10 bat, 11 sword.
- act_ready  out  1  the action can be accepted this cycle.
- turn  out  1  side to move: 0 player, 1 enemy.
- player_HP, enemy_HP  out  HP_W  current health.
- player_bat, player_sword, enemy_bat, enemy_sword  out  AMMO_W  remaining weapon uses.
- last_dmg  out  HP_W  damage applied by the last resolved action.
- last_hit  out  1  the last resolved action dealt damage.
- player_win, enemy_win  out  1  sticky result flags.

Function
REQ-008 SHALL implement the FSM states IDLE, P_TURN, E_TURN, RESOLVE and DONE:
- IDLE -> P_TURN when collision_detected=1 and this is the first battle after reset.
- IDLE -> the paused turn state when collision_detected=1 and a battle was paused.
REQ-009 SHALL drive act_ready = (P_TURN and act_who=0) or (E_TURN and act_who=1); a handshake occurs when act_valid and act_ready are both 1.
REQ-010 SHALL register act_choice and the attacker on a handshake, then enter RESOLVE; HP and ammo update at the end of the RESOLVE cycle, so outputs are visible 2 cycles after the handshake.
REQ-011 SHALL use a base damage of 10/20/30/40 for punch/kick/bat/sword, with a spread R of 2/4/6/8 respectively.
REQ-012 SHALL compute damage = base + ((lfsr[4:0] mod (2R+1)) - R), giving 8-12, 16-24, 24-36 or 32-48; the result is unsigned, HP_W wide.
REQ-013 SHALL use a 16-bit Fibonacci LFSR with taps 16,14,13,11, loaded with LFSR_SEED on reset and advanced every cycle, never stalled.
REQ-014 SHALL saturate the defender's HP: if HP <= dmg, HP becomes 0; otherwise HP becomes HP - dmg. HP never wraps.
REQ-015 SHALL decrement the attacker's counter by 1 when a bat or sword is used with a non-zero counter.
REQ-016 SHALL treat a bat or sword used with a zero counter as consumed with dmg=0 and last_hit=0; the counter stays at 0 and the turn still passes.
REQ-017 SHALL choose the next state after RESOLVE as follows: DONE if the defender's HP is 0; otherwise the opposing turn state, so turns strictly alternate.
REQ-018 SHALL set player_win=1 on entry to DONE when enemy_HP=0, or enemy_win=1 when player_HP=0; exactly one flag is ever set, and DONE is held until rst.
REQ-019 SHALL move from P_TURN or E_TURN to IDLE (pause) when collision_detected=0, keeping HP, ammo and turn; a RESOLVE in progress always completes first.
REQ-020 SHALL ignore act_valid with a mismatched act_who (no state change), and act_ready SHALL be 0 in IDLE, RESOLVE and DONE.

Reset
REQ-021 SHALL, while rst=1, set the state to IDLE, both HP outputs to HP_INIT, the bat counters to BAT_INIT and the sword counters to SWORD_INIT, and the LFSR to LFSR_SEED.
REQ-022 SHALL also, while rst=1, set turn, last_dmg, last_hit, player_win, enemy_win and act_ready to 0.
REQ-023 SHALL, when rst is asserted mid-RESOLVE, discard the pending action with no HP or ammo change surviving.

Configuration
REQ-024 SHALL compile an accuracy check in when macro BATTLE_ACCURACY_EN is defined:
- the hit threshold on lfsr[15:8] is 255 for punch, 204 for kick, 77 for bat and 102 for sword;
- the action hits only if lfsr[15:8] < threshold, except punch, which always hits;
- a miss applies dmg=0 and last_hit=0 but still consumes ammo and passes the turn.
REQ-025 SHALL, when BATTLE_ACCURACY_EN is undefined, make every action with available ammo hit.

Verification
REQ-026 SHALL cover: reset, collision=1, player punch -> 2 cycles later enemy_HP in 88..92, last_hit=1, turn=1.
REQ-027 SHALL cover: enemy offers while turn=0 -> act_ready=0; HP, ammo and turn unchanged.
REQ-028 SHALL cover: 4 player sword actions (SWORD_INIT=3) -> player_sword 3,2,1,0,0; fourth gives last_dmg=0, last_hit=0.
REQ-029 SHALL cover: enemy_HP forced low via repeated attacks -> enemy_HP=0 (no wrap), player_win=1, DONE holds, act_ready=0.
REQ-030 SHALL cover: collision dropped in E_TURN then restored -> resumes E_TURN, HP unchanged.
REQ-031 SHALL cover: rst pulse mid-RESOLVE -> HP 100/100, ammo 4/3, no win flags.

Source files
------------

// File: rtl/battle_engine_param.sv
// battle_engine_param: turn-based two-sided battle resolver with a
// free-running LFSR damage randomiser and saturating HP counters.
// Optional macro: BATTLE_ACCURACY_EN adds a per-weapon hit/miss roll.
// Ports:
//   clk, rst                 clock, async active-high reset
//   collision_detected       battle enable (0 pauses at a turn boundary)
//   act_valid/act_who/
//   act_choice/act_ready     action offer handshake (who: 0 player, 1 enemy)
//   turn                     side to move
//   player_HP, enemy_HP      health
//   player_bat/sword,
//   enemy_bat/sword          remaining weapon uses
//   last_dmg, last_hit       result of the last resolved action
//   player_win, enemy_win    sticky result flags
module battle_engine_param #(
    parameter int          HP_W       = 8,
    parameter int          HP_INIT    = 100,
    parameter int          AMMO_W     = 5,
    parameter int          BAT_INIT   = 4,
    parameter int          SWORD_INIT = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              collision_detected,
    input  logic              act_valid,
    input  logic              act_who,
    input  logic [1:0]        act_choice,
    output logic              act_ready,
    output logic              turn,
    output logic [HP_W-1:0]   player_HP,
    output logic [HP_W-1:0]   enemy_HP,
    output logic [AMMO_W-1:0] player_bat,
    output logic [AMMO_W-1:0] player_sword,
    output logic [AMMO_W-1:0] enemy_bat,
    output logic [AMMO_W-1:0] enemy_sword,
    output logic [HP_W-1:0]   last_dmg,
    output logic              last_hit,
    output logic              player_win,
    output logic              enemy_win
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_TURN  = 3'd1,
        E_TURN  = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [1:0]        choice_q;
    logic              who_q;

    logic [5:0]        base;
    logic [3:0]        spread;
    logic [4:0]        span;
    logic [4:0]        offset;
    logic [HP_W-1:0]   raw_dmg;
    logic [HP_W-1:0]   dmg;
    logic [HP_W-1:0]   def_hp;
    logic [HP_W-1:0]   new_hp;
    logic [AMMO_W-1:0] atk_bat;
    logic [AMMO_W-1:0] atk_sword;
    logic [AMMO_W-1:0] atk_cnt;
    logic              is_weapon;
    logic              has_ammo;
    logic              acc_hit;
    logic              hit;

    // Fibonacci LFSR, taps 16,14,13,11; runs every cycle regardless of state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        base   = 6'd10;
        spread = 4'd2;
        unique case (choice_q)
            2'b00: begin base = 6'd10; spread = 4'd2; end
            2'b01: begin base = 6'd20; spread = 4'd4; end
            2'b10: begin base = 6'd30; spread = 4'd6; end
            2'b11: begin base = 6'd40; spread = 4'd8; end
        endcase
    end

    // span = 2R+1; base >= R so the subtraction never underflows
    assign span    = {spread, 1'b1};
    assign offset  = lfsr[4:0] % span;
    assign raw_dmg = HP_W'(base) + HP_W'(offset) - HP_W'(spread);

    assign atk_bat   = who_q ? enemy_bat : player_bat;
    assign atk_sword = who_q ? enemy_sword : player_sword;
    assign atk_cnt   = choice_q[0] ? atk_sword : atk_bat;
    assign is_weapon = choice_q[1];
    assign has_ammo  = !is_weapon || (atk_cnt != '0);

`ifdef BATTLE_ACCURACY_EN
    logic [7:0] thr;

    always_comb begin
        thr = 8'd255;
        unique case (choice_q)
            2'b00: thr = 8'd255;
            2'b01: thr = 8'd204;
            2'b10: thr = 8'd77;
            2'b11: thr = 8'd102;
        endcase
    end

    // punch always lands even though lfsr[15:8] may equal 255
    assign acc_hit = (choice_q == 2'b00) || (lfsr[15:8] < thr);
`else
    assign acc_hit = 1'b1;
`endif

    assign hit    = has_ammo && acc_hit;
    assign dmg    = hit ? raw_dmg : '0;
    assign def_hp = who_q ? player_HP : enemy_HP;
    assign new_hp = (def_hp <= dmg) ? '0 : def_hp - dmg;

    assign act_ready = ((state == P_TURN) && !act_who) ||
                       ((state == E_TURN) && act_who);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            choice_q     <= 2'b00;
            who_q        <= 1'b0;
            turn         <= 1'b0;
            player_HP    <= HP_W'(HP_INIT);
            enemy_HP     <= HP_W'(HP_INIT);
            player_bat   <= AMMO_W'(BAT_INIT);
            enemy_bat    <= AMMO_W'(BAT_INIT);
            player_sword <= AMMO_W'(SWORD_INIT);
            enemy_sword  <= AMMO_W'(SWORD_INIT);
            last_dmg     <= '0;
            last_hit     <= 1'b0;
            player_win   <= 1'b0;
            enemy_win    <= 1'b0;
        end else begin
            case (state)
                // turn is 0 after reset, so resuming and first start coincide
                IDLE: begin
                    if (collision_detected) begin
                        state <= turn ? E_TURN : P_TURN;
                    end
                end
                P_TURN, E_TURN: begin
                    if (act_valid && act_ready) begin
                        choice_q <= act_choice;
                        who_q    <= act_who;
                        state    <= RESOLVE;
                    end else if (!collision_detected) begin
                        state <= IDLE;
                    end
                end
                RESOLVE: begin
                    last_dmg <= dmg;
                    last_hit <= hit;
                    if (who_q) begin
                        player_HP <= new_hp;
                    end else begin
                        enemy_HP <= new_hp;
                    end
                    if (is_weapon && has_ammo) begin
                        unique case ({who_q, choice_q[0]})
                            2'b00: player_bat   <= player_bat - AMMO_W'(1);
                            2'b01: player_sword <= player_sword - AMMO_W'(1);
                            2'b10: enemy_bat    <= enemy_bat - AMMO_W'(1);
                            2'b11: enemy_sword  <= enemy_sword - AMMO_W'(1);
                        endcase
                    end
                    if (new_hp == '0) begin
                        state <= DONE;
                        if (who_q) begin
                            enemy_win <= 1'b1;
                        end else begin
                            player_win <= 1'b1;
                        end
                    end else begin
                        turn  <= ~who_q;
                        state <= who_q ? P_TURN : E_TURN;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_engine_param.sv
// tb_battle_engine_param: directed + randomized bench for battle_engine_param
// with an arithmetic reference model of damage, HP, ammo and turn rules.
module tb_battle_engine_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       collision_detected = 1'b0;
    logic       act_valid = 1'b0;
    logic       act_who = 1'b0;
    logic [1:0] act_choice = 2'b00;
    logic       act_ready;
    logic       turn;
    logic [7:0] player_HP, enemy_HP, last_dmg;
    logic [4:0] player_bat, player_sword, enemy_bat, enemy_sword;
    logic       last_hit, player_win, enemy_win;

    int checks = 0;
    int errors = 0;

    int m_php, m_ehp, m_pbat, m_psw, m_ebat, m_esw;
    int m_turn, m_pwin, m_ewin, m_done;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    battle_engine_param dut (
        .clk(clk),
        .rst(rst),
        .collision_detected(collision_detected),
        .act_valid(act_valid),
        .act_who(act_who),
        .act_choice(act_choice),
        .act_ready(act_ready),
        .turn(turn),
        .player_HP(player_HP),
        .enemy_HP(enemy_HP),
        .player_bat(player_bat),
        .player_sword(player_sword),
        .enemy_bat(enemy_bat),
        .enemy_sword(enemy_sword),
        .last_dmg(last_dmg),
        .last_hit(last_hit),
        .player_win(player_win),
        .enemy_win(enemy_win)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // random source of the design, stepped once per clock from the seed
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    // base 10/20/30/40, spread R 2/4/6/8
    function automatic int dmg_of(input int ch, input logic [15:0] l);
        int r;
        int v;
        r = 2 * (ch + 1);
        v = int'(l[4:0]);
        return 10 * (ch + 1) + (v % (2 * r + 1)) - r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":player_HP"}, 32'(player_HP), m_php);
        chk({tag, ":enemy_HP"}, 32'(enemy_HP), m_ehp);
        chk({tag, ":player_bat"}, 32'(player_bat), m_pbat);
        chk({tag, ":player_sword"}, 32'(player_sword), m_psw);
        chk({tag, ":enemy_bat"}, 32'(enemy_bat), m_ebat);
        chk({tag, ":enemy_sword"}, 32'(enemy_sword), m_esw);
        chk({tag, ":turn"}, 32'(turn), m_turn);
        chk({tag, ":player_win"}, 32'(player_win), m_pwin);
        chk({tag, ":enemy_win"}, 32'(enemy_win), m_ewin);
    endtask

    task automatic model_init();
        m_php = 100; m_ehp = 100;
        m_pbat = 4; m_ebat = 4;
        m_psw = 3; m_esw = 3;
        m_turn = 0; m_pwin = 0; m_ewin = 0; m_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        collision_detected = 1'b0;
        act_valid = 1'b0;
        act_who = 1'b0;
        act_choice = 2'b00;
        model_init();
        @(posedge clk);
        @(negedge clk);
        chk_all("reset");
        chk("reset:last_dmg", 32'(last_dmg), 0);
        chk("reset:last_hit", 32'(last_hit), 0);
        chk("reset:ready_p", 32'(act_ready), 0);
        act_who = 1'b1;
        #1 chk("reset:ready_e", 32'(act_ready), 0);
        act_who = 1'b0;
        rst = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        collision_detected = 1'b1;
        @(posedge clk);
    endtask

    // offer one action, let it resolve, check against the model;
    // low=1 delays the offer until the roll gives the smallest sword spread
    task automatic act(input logic who, input logic [1:0] ch, input bit low);
        logic [15:0] l;
        logic [15:0] nx;
        int n, d, cnt, ci;
        bit hit;
        ci = int'(ch);
        @(negedge clk);
        if (low) begin
            n = 0;
            nx = lfsr_next(m_lfsr);
            while (n < 400 && (int'(nx[4:0]) % 17) > 1) begin
                @(negedge clk);
                nx = lfsr_next(m_lfsr);
                n++;
            end
            if (n >= 400) begin
                errors++;
                $display("FAIL lfsr_wait observed=%0d expected<400", n);
            end
        end
        act_valid = 1'b1;
        act_who = who;
        act_choice = ch;
        #1 chk("act:ready", 32'(act_ready), 1);
        @(posedge clk);
        @(negedge clk);
        act_valid = 1'b0;
        chk("act:ready_resolve", 32'(act_ready), 0);
        l = m_lfsr;
        if (ci == 2)      cnt = who ? m_ebat : m_pbat;
        else if (ci == 3) cnt = who ? m_esw : m_psw;
        else              cnt = 1;
        hit = (cnt > 0);
`ifdef BATTLE_ACCURACY_EN
        if (ci == 1 && int'(l[15:8]) >= 204) hit = 1'b0;
        if (ci == 2 && int'(l[15:8]) >= 77)  hit = 1'b0;
        if (ci == 3 && int'(l[15:8]) >= 102) hit = 1'b0;
`endif
        d = hit ? dmg_of(ci, l) : 0;
        if (who) m_php = (m_php <= d) ? 0 : m_php - d;
        else     m_ehp = (m_ehp <= d) ? 0 : m_ehp - d;
        if (ci >= 2 && cnt > 0) begin
            if (who && ci == 2)       m_ebat--;
            else if (who)             m_esw--;
            else if (ci == 2)         m_pbat--;
            else                      m_psw--;
        end
        if ((who ? m_php : m_ehp) == 0) begin
            m_done = 1;
            if (who) m_ewin = 1;
            else     m_pwin = 1;
        end else begin
            m_turn = who ? 0 : 1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("act:last_dmg", 32'(last_dmg), d);
        chk("act:last_hit", 32'(last_hit), 32'(hit));
        chk_all("act");
    endtask

    task automatic hold_done();
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            act_valid = 1'b1;
            act_who = 1'(w);
            act_choice = 2'b01;
            #1 chk("done:ready", 32'(act_ready), 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            act_valid = 1'b0;
            chk_all("done_hold");
            chk("done:one_flag", 32'(player_win) + 32'(enemy_win), 1);
        end
    endtask

    initial begin
        // scenario A: mismatch, first punch, pause/resume, random battle
        do_reset();
        start();
        @(negedge clk);
        act_valid = 1'b1;
        act_who = 1'b1;
        act_choice = 2'b11;
        #1 chk("mismatch:ready", 32'(act_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        act_valid = 1'b0;
        chk_all("mismatch");

        act(1'b0, 2'b00, 1'b0);
        chk("punch:range", 32'(enemy_HP >= 88 && enemy_HP <= 92), 1);
        chk("punch:hit", 32'(last_hit), 1);
        chk("punch:turn", 32'(turn), 1);

        @(negedge clk);
        collision_detected = 1'b0;
        @(posedge clk);
        @(negedge clk);
        act_valid = 1'b1;
        act_who = 1'b1;
        act_choice = 2'b00;
        #1 chk("paused:ready", 32'(act_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        act_valid = 1'b0;
        chk_all("paused");
        collision_detected = 1'b1;
        @(posedge clk);
        act(1'b1, 2'($urandom_range(0, 3)), 1'b0);

        for (int i = 0; i < 40 && m_done == 0; i++) begin
            act(1'(m_turn), 2'($urandom_range(0, 3)), 1'b0);
        end
        chk("rand:finished", 32'(m_done), 1);
        if (m_done != 0) hold_done();

        // scenario B: sword exhaustion, then player drives enemy to zero
        do_reset();
        start();
        for (int k = 0; k < 4; k++) begin
            act(1'b0, 2'b11, 1'b1);
            chk("sword:left", 32'(player_sword), (k < 3) ? 2 - k : 0);
            if (k == 3) begin
                chk("sword:empty_dmg", 32'(last_dmg), 0);
                chk("sword:empty_hit", 32'(last_hit), 0);
            end
            act(1'b1, 2'b00, 1'b0);
        end
        for (int i = 0; i < 30 && m_done == 0; i++) begin
            if (m_turn != 0) act(1'b1, 2'b00, 1'b0);
            else             act(1'b0, 2'b01, 1'b0);
        end
        chk("kill:enemy_HP", 32'(enemy_HP), 0);
        chk("kill:player_win", 32'(player_win), 1);
        chk("kill:enemy_win", 32'(enemy_win), 0);
        hold_done();
        chk("kill:enemy_HP_held", 32'(enemy_HP), 0);

        // scenario C: reset asserted while a sword action is resolving
        do_reset();
        start();
        @(negedge clk);
        act_valid = 1'b1;
        act_who = 1'b0;
        act_choice = 2'b11;
        #1 chk("rstmid:ready", 32'(act_ready), 1);
        @(posedge clk);
        @(negedge clk);
        act_valid = 1'b0;
        rst = 1'b1;
        model_init();
        @(posedge clk);
        @(negedge clk);
        chk_all("rstmid");
        chk("rstmid:last_dmg", 32'(last_dmg), 0);
        chk("rstmid:last_hit", 32'(last_hit), 0);
        rst = 1'b0;
        collision_detected = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
